// File: rtl/alu_io_pkg.sv
// Shared types and constants for the ALU operand I/O path.
package alu_io_pkg;

   // Field currently being edited by the operand entry state machine
   typedef enum logic [1:0] {
      SIGN = 2'd0,
      TENS = 2'd1,
      ONES = 2'd2,
      DONE = 2'd3
   } field_e;

   localparam int unsigned OPERAND_W      = 6;
   localparam int unsigned OP_MAX_POS     = 31;
   localparam int unsigned OP_MAX_NEG_MAG = 32;
   localparam int unsigned TENS_MAX       = 3;
   localparam int unsigned ONES_MAX       = 9;

endpackage

// File: rtl/operand_entry_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability filter, one-cycle
// pulse on an accepted rising level.
//   clk, reset : clock, synchronous active-high reset
//   i_raw      : raw asynchronous button level (active-high)
//   o_pulse    : one-cycle pulse when a press has been accepted
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_pulse
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync0;
   logic             r_sync1;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pulse;
   logic             w_accept;

   // Synchronized level has differed from the accepted level long enough
   assign w_accept = (r_sync1 != r_stable) && (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync0  <= 1'b0;
         r_sync1  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
         r_pulse  <= 1'b0;
      end else begin
         r_sync0 <= i_raw;
         r_sync1 <= r_sync0;
         // Count only while the input disagrees with the accepted level;
         // any return to agreement restarts the window.
         if (r_sync1 == r_stable || w_accept) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_accept) begin
            r_stable <= r_sync1;
         end
         // Pulse only on an accepted press, never on a release
         r_pulse <= w_accept && r_sync1;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/operand_entry.sv
// Push-button entry of one signed decimal operand (-32..+31), committed as
// saturated 6-bit two's complement onto the ALU operand bus.
//   clk, reset        : clock, synchronous active-high reset
//   btn_inc           : raw button, increment/toggle current field
//   btn_next          : raw button, advance field or commit
//   btn_clr           : raw button, abort and clear
//   operand, valid    : committed value and its qualifier
//   field             : field being edited (SIGN/TENS/ONES/DONE)
//   neg, tens, ones   : current entry digits for display
module operand_entry
   import alu_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_inc,
   input  logic                 btn_next,
   input  logic                 btn_clr,
   output logic [OPERAND_W-1:0] operand,
   output logic                 valid,
   output logic [1:0]           field,
   output logic                 neg,
   output logic [3:0]           tens,
   output logic [3:0]           ones
);

   logic w_inc_p;
   logic w_next_p;
   logic w_clr_p;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk(clk), .reset(reset), .i_raw(btn_inc), .o_pulse(w_inc_p)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk(clk), .reset(reset), .i_raw(btn_next), .o_pulse(w_next_p)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
      .clk(clk), .reset(reset), .i_raw(btn_clr), .o_pulse(w_clr_p)
   );

   field_e               r_field;
   logic                 r_neg;
   logic [3:0]           r_tens;
   logic [3:0]           r_ones;
   logic [OPERAND_W-1:0] r_operand;
   logic                 r_valid;

   logic [OPERAND_W-1:0] w_mag;
   logic [OPERAND_W-1:0] w_pos;
   logic [OPERAND_W-1:0] w_neg_mag;
   logic [OPERAND_W-1:0] w_commit;

   // Commit arithmetic: decimal magnitude, saturated per sign
   assign w_mag     = OPERAND_W'(r_tens) * OPERAND_W'(10) + OPERAND_W'(r_ones);
   assign w_pos     = (w_mag > OPERAND_W'(OP_MAX_POS)) ? OPERAND_W'(OP_MAX_POS) : w_mag;
   assign w_neg_mag = (w_mag > OPERAND_W'(OP_MAX_NEG_MAG)) ? OPERAND_W'(OP_MAX_NEG_MAG) : w_mag;
   // Magnitude 32 negates to 6'b100000; magnitude 0 negates to 0
   assign w_commit  = r_neg ? OPERAND_W'(~w_neg_mag + OPERAND_W'(1)) : w_pos;

   // Field-select FSM; clr beats next beats inc
   always_ff @(posedge clk) begin
      if (reset) begin
         r_field   <= SIGN;
         r_neg     <= 1'b0;
         r_tens    <= 4'd0;
         r_ones    <= 4'd0;
         r_operand <= '0;
         r_valid   <= 1'b0;
      end else if (w_clr_p) begin
         r_field   <= SIGN;
         r_neg     <= 1'b0;
         r_tens    <= 4'd0;
         r_ones    <= 4'd0;
         r_operand <= '0;
         r_valid   <= 1'b0;
      end else if (w_next_p) begin
         case (r_field)
            SIGN: r_field <= TENS;
            TENS: r_field <= ONES;
            ONES: begin
               r_field   <= DONE;
               r_operand <= w_commit;
               r_valid   <= 1'b1;
            end
            // Back to editing; digits and operand kept for re-edit
            DONE: begin
               r_field <= SIGN;
               r_valid <= 1'b0;
            end
            default: r_field <= SIGN;
         endcase
      end else if (w_inc_p) begin
         case (r_field)
            SIGN: r_neg  <= ~r_neg;
            TENS: r_tens <= (r_tens == 4'(TENS_MAX)) ? 4'd0 : r_tens + 4'd1;
            ONES: r_ones <= (r_ones == 4'(ONES_MAX)) ? 4'd0 : r_ones + 4'd1;
            default: ;
         endcase
      end
   end

   assign operand = r_operand;
   assign valid   = r_valid;
   assign field   = r_field;
   assign neg     = r_neg;
   assign tens    = r_tens;
   assign ones    = r_ones;

endmodule
